univ_sync_fifo_ext: RTL and testbench
=====================================

// Module: univ_sync_fifo_ext
// PURPOSE
//   Parametrised single-clock FIFO that extends our basic sync FIFO with:
//   - selectable first-word-fall-through (FWFT) read mode
//   - occupancy count and programmable almost-full/almost-empty flags
//   - sticky overflow/underflow error flags and a synchronous flush
//   Used as the common buffering block between streaming datapath stages.
// PARAMETERS
//   DATA_WIDTH  32  data word width, >=1
//   FIFO_DEPTH  8   number of entries; power of two, >=2
//   FWFT        0   0 = registered read, 1 = first-word-fall-through
//   AF_THRESH   6   almost_full asserted when count >= AF_THRESH (1..FIFO_DEPTH)
//   AE_THRESH   1   almost_empty asserted when count <= AE_THRESH (0..FIFO_DEPTH-1)
// PORTS
//   clk           in   1            single clock, rising edge
//   rst_n         in   1            asynchronous, active-low reset
//   cs            in   1            chip select; gates wr_en, rd_en, flush, clr_err
//   wr_en         in   1            write request
//   rd_en         in   1            read request (pop)
//   flush         in   1            synchronous clear of contents
//   clr_err       in   1            clears sticky error flags
//   data_in       in   DATA_WIDTH   write data
//   data_out      out  DATA_WIDTH   read data
//   empty         out  1            no entries
//   full          out  1            FIFO_DEPTH entries
//   almost_empty  out  1            count <= AE_THRESH
//   almost_full   out  1            count >= AF_THRESH
//   count         out  AW+1         occupancy, AW = $clog2(FIFO_DEPTH)
//   overflow      out  1            sticky: write attempted while full
//   underflow     out  1            sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - pointers = 0, count = 0, data_out = 0
//     - empty = 1, full = 0, almost_empty = 1, almost_full = 0
//     - overflow = 0, underflow = 0
//   - Pointers are AW+1 bits; the MSB is the wrap bit.
//     - empty: rd_ptr == wr_ptr
//     - full: addresses equal and wrap bits differ
//     - Pointers wrap naturally modulo 2*FIFO_DEPTH.
//   - Accept rules use flag state at the start of the cycle:
//     - write accepted = cs & wr_en & !full & !flush
//     - read accepted  = cs & rd_en & !empty & !flush
//   - Full with wr+rd in the same cycle: read accepted, write rejected,
//     overflow set. No bypass.
//   - Empty with wr+rd in the same cycle: write accepted, read rejected,
//     underflow set.
//   - count is registered:
//     - +1 on write only, -1 on read only
//     - unchanged when both are accepted
//     - never exceeds FIFO_DEPTH
//   - Flags (empty, full, almost_*) are combinational from registered
//     pointers/count, so they update in the cycle after the accepted access.
//   - FWFT=0: data_out <= mem[rd_addr] on an accepted read (1-cycle latency);
//     otherwise data_out holds.
//   - FWFT=1: data_out = mem[rd_addr] when !empty, else 0 (combinational).
//     - An accepted read pops, and the next word is visible the following cycle.
//     - A write into an empty FIFO is visible on data_out one cycle after the write.
//   - flush (cs & flush):
//     - pointers and count go to 0 next edge; data_out goes to 0
//     - memory contents are untouched
//     - wr/rd in the same cycle are ignored and raise no errors
//   - Error flags: set on a rejected access attempt, clear on cs & clr_err.
//     If set and clear happen in the same cycle, set wins.
//   - Reset mid-operation: all state returns to reset values immediately.
//     Memory array is not reset.
// STRUCTURE
//   - Shared package univ_fifo_pkg holds:
//     - mode constants FWFT_OFF=0, FWFT_ON=1
//     - ptr_width(depth) helper returning $clog2(depth)+1
//   - Sub-module univ_fifo_mem: simple dual-port register array
//     - 1 write port (clocked), 1 asynchronous read port
//     - parameters DATA_WIDTH, FIFO_DEPTH
//   - Top level holds pointers, count, flags, error logic and the FWFT/registered output mux.
// TESTING (DATA_WIDTH=32, FIFO_DEPTH=8, AF=6, AE=1 unless noted)
//   - Fill/drain, FWFT=0: write 0x00..0x07 -> full=1, count=8, almost_full from the
//     6th write; read 8 -> data_out 0x00..0x07, each 1 cycle after rd_en; empty=1.
//   - FWFT=1: write 0xA5 into empty -> data_out=0xA5 next cycle with empty=0;
//     rd_en -> empty=1 and data_out=0 next cycle.
//   - Wrap-around: 5 writes, 5 reads, then 8 writes and 8 reads -> data order
//     preserved and count goes 0->8->0.
//   - Boundaries: when full, wr+rd in one cycle -> count=7, overflow=1; when empty,
//     wr+rd in one cycle -> count=1, underflow=1; then clr_err -> both flags 0.
//   - Flush with 4 entries plus wr_en -> count=0, empty=1, no error flags set;
//     a subsequent write/read returns the new word.
//   - rst_n low mid-burst at count=5 -> all outputs at reset values in the same cycle;
//     after release, the first read returns the first post-reset write.

Source files
------------

// File: rtl/univ_fifo_pkg.sv
// Shared definitions for the universal sync FIFO family.
//   FWFT_OFF / FWFT_ON : read-mode selectors for the FWFT parameter
//   ptr_width(depth)   : pointer width incl. wrap bit = $clog2(depth)+1
package univ_fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/univ_fifo_mem.sv
// Simple dual-port register array: one clocked write port and one
// asynchronous read port. Contents are not reset.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data (combinational from rd_addr)
module univ_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(FIFO_DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [$clog2(FIFO_DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/univ_sync_fifo_ext.sv
// Single-clock FIFO with selectable FWFT read mode, occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags and a synchronous flush.
//   clk, rst_n      : clock (rising edge), async active-low reset
//   cs              : chip select gating wr_en, rd_en, flush, clr_err
//   wr_en, rd_en    : push / pop requests
//   flush           : synchronous clear of pointers and count
//   clr_err         : clears sticky error flags
//   data_in         : write data
//   data_out        : read data (registered or fall-through per FWFT)
//   empty, full     : occupancy extremes
//   almost_empty    : count <= AE_THRESH
//   almost_full     : count >= AF_THRESH
//   count           : occupancy 0..FIFO_DEPTH
//   overflow        : sticky, write attempted while full
//   underflow       : sticky, read attempted while empty
module univ_sync_fifo_ext
    import univ_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FWFT       = FWFT_OFF,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic                          flush,
    input  logic                          clr_err,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = ptr_width(FIFO_DEPTH);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   AF_LVL  = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   AE_LVL  = (AW+1)'(AE_THRESH);

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           cnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  do_flush, wr_acc, rd_acc, wr_rej, rd_rej;

    assign empty        = (rd_ptr == wr_ptr);
    assign full         = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign count        = cnt;
    assign almost_full  = (cnt >= AF_LVL);
    assign almost_empty = (cnt <= AE_LVL);

    // Flush masks both accesses so a flushing cycle can never raise an error.
    assign do_flush = cs & flush;
    assign wr_acc   = cs & wr_en & ~full  & ~flush;
    assign rd_acc   = cs & rd_en & ~empty & ~flush;
    assign wr_rej   = cs & wr_en &  full  & ~flush;
    assign rd_rej   = cs & rd_en &  empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_acc && !rd_acc)
                cnt <= cnt + CNT_ONE;
            else if (rd_acc && !wr_acc)
                cnt <= cnt - CNT_ONE;
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_rej)
                overflow <= 1'b1;
            else if (cs && clr_err)
                overflow <= 1'b0;
            if (rd_rej)
                underflow <= 1'b1;
            else if (cs && clr_err)
                underflow <= 1'b0;
        end
    end

    univ_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // Head word is exposed directly; forced to zero when nothing is stored.
            assign data_out = empty ? '0 : rd_data;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    dout_q <= '0;
                else if (do_flush)
                    dout_q <= '0;
                else if (rd_acc)
                    dout_q <= rd_data;
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_univ_sync_fifo_ext.sv
module tb_univ_sync_fifo_ext;
    import univ_fifo_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs, wr_en, rd_en, flush, clr_err;
    logic [DW-1:0] data_in;

    logic [DW-1:0] data_out0, data_out1;
    logic          empty0, full0, ae0, af0, ov0, un0;
    logic          empty1, full1, ae1, af1, ov1, un1;
    logic [3:0]    count0, count1;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: a queue of stored words plus sticky flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ov, m_un;

    always #5 clk = ~clk;

    univ_sync_fifo_ext #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .FWFT       (FWFT_OFF),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) u_dut_reg (
        .clk (clk), .rst_n (rst_n), .cs (cs), .wr_en (wr_en), .rd_en (rd_en),
        .flush (flush), .clr_err (clr_err), .data_in (data_in), .data_out (data_out0),
        .empty (empty0), .full (full0), .almost_empty (ae0), .almost_full (af0),
        .count (count0), .overflow (ov0), .underflow (un0)
    );

    univ_sync_fifo_ext #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .FWFT       (FWFT_ON),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) u_dut_fwft (
        .clk (clk), .rst_n (rst_n), .cs (cs), .wr_en (wr_en), .rd_en (rd_en),
        .flush (flush), .clr_err (clr_err), .data_in (data_in), .data_out (data_out1),
        .empty (empty1), .full (full1), .almost_empty (ae1), .almost_full (af1),
        .count (count1), .overflow (ov1), .underflow (un1)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_flags();
        int sz = q.size();
        return {sz == 0, sz == DEPTH, sz <= 1, sz >= 6, m_ov, m_un};
    endfunction

    task automatic compare_all();
        logic [DW-1:0] head;
        head = (q.size() == 0) ? '0 : q[0];
        check_val("dout_reg",   data_out0, m_dout);
        check_val("dout_fwft",  data_out1, head);
        check_val("count_reg",  count0, q.size());
        check_val("count_fwft", count1, q.size());
        check_val("flags_reg",  {empty0, full0, ae0, af0, ov0, un0}, model_flags());
        check_val("flags_fwft", {empty1, full1, ae1, af1, ov1, un1}, model_flags());
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    // Apply one clock of stimulus, advance the model, then compare.
    task automatic step(input logic c, input logic w, input logic r, input logic f,
                        input logic e, input logic [DW-1:0] d);
        logic was_full, was_empty;
        cs = c; wr_en = w; rd_en = r; flush = f; clr_err = e; data_in = d;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (c && f) begin
            q.delete();
            m_dout = '0;
        end else begin
            if (c && r && !was_empty)
                m_dout = q.pop_front();
            if (c && w && !was_full)
                q.push_back(d);
        end
        if (c && w && was_full && !f)
            m_ov = 1'b1;
        else if (c && e)
            m_ov = 1'b0;
        if (c && r && was_empty && !f)
            m_un = 1'b1;
        else if (c && e)
            m_un = 1'b0;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill / drain
        for (int unsigned i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 0, DW'(i));
            check_val("af_edge", af0, (i >= 5));
        end
        check_val("fill_count", count0, 8);
        check_val("fill_full", full0, 1);
        for (int unsigned i = 0; i < 8; i++) begin
            step(1, 0, 1, 0, 0, '0);
            check_val("drain_data", data_out0, i);
        end
        check_val("drain_empty", empty0, 1);

        // FWFT visibility
        step(1, 1, 0, 0, 0, 32'hA5);
        check_val("fwft_a5", data_out1, 32'hA5);
        check_val("fwft_nempty", empty1, 0);
        step(1, 0, 1, 0, 0, '0);
        check_val("fwft_empty", empty1, 1);
        check_val("fwft_zero", data_out1, 0);

        // Wrap-around
        for (int unsigned i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 32'h100 + i);
        for (int unsigned i = 0; i < 5; i++) step(1, 0, 1, 0, 0, '0);
        for (int unsigned i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 32'h200 + i);
        check_val("wrap_count8", count0, 8);
        for (int unsigned i = 0; i < 8; i++) begin
            step(1, 0, 1, 0, 0, '0);
            check_val("wrap_data", data_out0, 32'h200 + i);
        end

        // Full / empty boundaries with simultaneous wr+rd
        for (int unsigned i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 32'h300 + i);
        step(1, 1, 1, 0, 0, 32'hDEAD);
        check_val("full_wr_rd_count", count0, 7);
        check_val("full_wr_rd_ovf", ov0, 1);
        for (int unsigned i = 0; i < 7; i++) step(1, 0, 1, 0, 0, '0);
        step(1, 1, 1, 0, 0, 32'h400);
        check_val("empty_wr_rd_count", count0, 1);
        check_val("empty_wr_rd_unf", un0, 1);
        step(1, 0, 0, 0, 1, '0);
        check_val("clr_err", {ov0, un0}, 2'b00);

        // Flush with pending write
        for (int unsigned i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 32'h500 + i);
        check_val("pre_flush_count", count0, 4);
        step(1, 1, 0, 1, 0, 32'h5FF);
        check_val("flush_count", count0, 0);
        check_val("flush_empty", empty0, 1);
        check_val("flush_errs", {ov0, un0}, 2'b00);
        step(1, 1, 0, 0, 0, 32'h1234);
        step(1, 0, 1, 0, 0, '0);
        check_val("post_flush_data", data_out0, 32'h1234);

        // Reset mid-burst at count 5
        for (int unsigned i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 32'h600 + i);
        #3;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_mid_count", count0, 0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 1, 0, 0, 0, 32'hBEEF);
        step(1, 0, 1, 0, 0, '0);
        check_val("post_rst_data", data_out0, 32'hBEEF);

        // Randomised traffic with drifting write/read bias
        for (int unsigned blk = 0; blk < 12; blk++) begin
            int unsigned wp = $urandom_range(20, 85);
            for (int unsigned k = 0; k < 50; k++) begin
                step(($urandom_range(0, 99) < 92),
                     ($urandom_range(0, 99) < wp),
                     ($urandom_range(0, 99) < (105 - wp)),
                     ($urandom_range(0, 99) < 3),
                     ($urandom_range(0, 99) < 6),
                     $urandom());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
